uart_apb_ctrl: RTL

- APB-facing controller that configures and sequences the SoC UART transmitter and receiver.
- Holds the UART configuration register and a TX FIFO. Feeds bytes to the transmitter one at a time through an idle-flag handshake.
- Drains received bytes into a holding register with overrun detection, and raises a combined interrupt.
- Sits between the APB bus and the UART TX/RX datapaths.

---
 rtl/uart_apb_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB register front-end for the SoC UART.
// Holds CTRL and a TX FIFO, and feeds the transmitter one byte at a time
// using its idle flag as a handshake. Received bytes are drained into a
// holding register with overrun detection. A single registered irq is
// raised from the TX and RX sources.
module uart_apb_ctrl #(
  parameter int TX_DEPTH    = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        spen,
  output logic        txen,
  output logic        rxen,
  output logic [1:0]  baud_sel,
  output logic [1:0]  uart_control,
  output logic [7:0]  tx_wdata,
  output logic        tx_we,
  input  logic        tx_idle,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  output logic        rx_re,
  output logic        irq
);

  localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} tx_state_e;

  // APB decode; misaligned accesses answer with PSLVERR and have no side effects
  logic       access, wr, rd, addr_ok;
  logic [1:0] sel;
  logic       wr_txd, rd_rxd, wr_ctrl, wr_stat, flush;

  assign access  = PSEL & PENABLE;
  assign wr      = access & PWRITE;
  assign rd      = access & ~PWRITE;
  assign addr_ok = (PADDR[1:0] == 2'b00);
  assign sel     = PADDR[3:2];
  assign wr_txd  = wr & addr_ok & (sel == 2'd0);
  assign rd_rxd  = rd & addr_ok & (sel == 2'd1);
  assign wr_ctrl = wr & addr_ok & (sel == 2'd2);
  assign wr_stat = wr & addr_ok & (sel == 2'd3);
  assign flush   = wr_ctrl & PWDATA[9];

  assign PREADY  = 1'b1;
  assign PSLVERR = access & ~addr_ok;

  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA[31:10];

  // ---------------- state ----------------
  logic [8:0]       ctrl_q;
  logic [7:0]       mem_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  tx_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       tx_wdata_q;
  logic             arm_q, rx_valid_q, rx_ovr_q, tx_ovf_q, tx_err_q, irq_q;
  logic [7:0]       rx_hold_q;

  logic fifo_empty, fifo_full, tx_busy, pop, push_acc, push_drop, tx_err_set;
  logic rx_fire, rx_take;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(TX_DEPTH));
  assign tx_busy    = (state_q != S_IDLE);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push_acc   = wr_txd & ~flush & (~fifo_full | pop);
  assign push_drop  = wr_txd & fifo_full & ~pop;

  assign spen         = ctrl_q[0];
  assign txen         = ctrl_q[1];
  assign rxen         = ctrl_q[2];
  assign baud_sel     = ctrl_q[4:3];
  assign uart_control = ctrl_q[6:5];
  assign tx_wdata     = tx_wdata_q;
  assign tx_we        = (state_q == S_LOAD);
  assign irq          = irq_q;

  // CTRL register; a write carrying TXFLUSH only flushes and leaves CTRL alone
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                ctrl_q <= '0;
    else if (wr_ctrl && !flush)  ctrl_q <= PWDATA[8:0];
  end

  // FIFO storage (no reset needed, validity is tracked by the pointers)
  always_ff @(posedge PCLK) begin
    if (push_acc) mem_q[wr_ptr_q] <= PWDATA[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      cnt_q    <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_acc, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // TX sequencer next-state: pop, strobe, wait for busy, wait for idle
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pop        = 1'b0;
    tx_err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && spen && txen && tx_idle) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_idle) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // transmitter never took the byte: give up on it
          tx_err_set = 1'b1;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // TX sequencer registers; tx_wdata holds until the next pop
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      tx_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pop) tx_wdata_q <= mem_q[rd_ptr_q];
    end
  end

  // RX drain: one rx_re per rising rx_flag; a read in the capture cycle
  // frees the holding register, so the new byte is kept without overrun
  assign rx_fire = rxen & spen & rx_flag & arm_q;
  assign rx_re   = rx_fire;
  assign rx_take = rx_fire & (~rx_valid_q | rd_rxd);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      arm_q      <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_hold_q  <= '0;
    end else begin
      if (rx_fire)       arm_q <= 1'b0;
      else if (!rx_flag) arm_q <= 1'b1;
      if (rx_take) begin
        rx_hold_q  <= rx_data;
        rx_valid_q <= 1'b1;
      end else if (rd_rxd) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Sticky error bits: hardware set beats a same-cycle W1C
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_ovr_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      tx_err_q <= 1'b0;
    end else begin
      if (rx_fire && !rx_take)      rx_ovr_q <= 1'b1;
      else if (wr_stat && PWDATA[4]) rx_ovr_q <= 1'b0;
      if (push_drop)                tx_ovf_q <= 1'b1;
      else if (wr_stat && PWDATA[5]) tx_ovf_q <= 1'b0;
      if (tx_err_set)               tx_err_q <= 1'b1;
      else if (wr_stat && PWDATA[6]) tx_err_q <= 1'b0;
    end
  end

  // Registered interrupt, one cycle behind its sources
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) irq_q <= 1'b0;
    else          irq_q <= (ctrl_q[7] & fifo_empty & ~tx_busy) |
                           (ctrl_q[8] & (rx_valid_q | rx_ovr_q));
  end

  // FIFO count shown in STATUS saturates at 15
  logic [31:0] cnt_ext;
  logic [3:0]  cnt_disp;
  always_comb begin
    cnt_ext  = 32'(cnt_q);
    cnt_disp = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
  end

  // Read mux, combinational during the access phase only
  always_comb begin
    PRDATA = '0;
    if (access) begin
      case (sel)
        2'd1:    if (rx_valid_q) PRDATA = {24'b0, rx_hold_q};
        2'd2:    PRDATA = {23'b0, ctrl_q};
        2'd3:    PRDATA = {20'b0, cnt_disp, 1'b0, tx_err_q, tx_ovf_q, rx_ovr_q,
                           rx_valid_q, tx_busy, fifo_full, fifo_empty};
        default: PRDATA = '0;
      endcase
    end
  end

endmodule
